xgmii_frame_tx: RTL and testbench

PHY-side XGMII frame transmitter. It drives the MAC's XGMII receive lanes (xgmii_rxd/xgmii_rxc), so it sits at the opposite end of the link from the MAC's XGMII transmitter.
- Accepts packet words on a POS-L3-style valid/ready push interface.
- Adds the start/preamble/SFD column, terminate and idle columns, and the inter-frame gap.
- Provides underrun abort and per-word error injection for RX-path checking.

---
 rtl/xgmii_tx_pkg.sv | 24 ++
 rtl/xgmii_frame_tx_if.sv | 16 +
 rtl/xgmii_term_encode.sv | 37 +++
 rtl/xgmii_frame_tx.sv | 145 ++++++++++++++
 tb/tb_xgmii_frame_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/xgmii_tx_pkg.sv
// Shared XGMII encoding constants, canned columns and the transmitter state
// type for the PHY-side XGMII frame transmitter.
package xgmii_tx_pkg;

  localparam logic [7:0] XGMII_IDLE    = 8'h07;
  localparam logic [7:0] XGMII_START   = 8'hFB;
  localparam logic [7:0] XGMII_TERM    = 8'hFD;
  localparam logic [7:0] XGMII_ERROR   = 8'hFE;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Lane 0 is the least significant byte and goes out first.
  localparam logic [63:0] IDLE_COLUMN  = {8{XGMII_IDLE}};
  localparam logic [63:0] START_COLUMN = {SFD_BYTE, {6{PREAMBLE_BYTE}}, XGMII_START};
  localparam logic [63:0] TERM_COLUMN  = {{7{XGMII_IDLE}}, XGMII_TERM};
  // Underrun abort: /E/ then /T/ so the MAC sees a terminated, errored frame.
  localparam logic [63:0] ABORT_COLUMN = {{6{XGMII_IDLE}}, XGMII_TERM, XGMII_ERROR};

  localparam logic [7:0] CTRL_ALL   = 8'hFF;
  localparam logic [7:0] CTRL_START = 8'h01;

  typedef enum logic [2:0] {IDLE, DATA, TERM, DRAIN, IFG} state_e;

endpackage

// File: rtl/xgmii_frame_tx_if.sv
// Packet push interface (valid/ready, sop/eop/mod framing, error inject).
//   master: upstream packet source     slave: xgmii_frame_tx
interface xgmii_frame_tx_if;
  logic        pkt_val;
  logic        pkt_sop;
  logic        pkt_eop;
  logic [2:0]  pkt_mod;
  logic [63:0] pkt_data;
  logic        pkt_err_inj;
  logic        pkt_rdy;

  modport master (output pkt_val, pkt_sop, pkt_eop, pkt_mod, pkt_data, pkt_err_inj,
                  input  pkt_rdy);
  modport slave  (input  pkt_val, pkt_sop, pkt_eop, pkt_mod, pkt_data, pkt_err_inj,
                  output pkt_rdy);
endinterface

// File: rtl/xgmii_term_encode.sv
// Combinational column encoder for an accepted packet word.
//   data    : packet bytes, lane k = data[8k+7:8k]
//   mod     : 0 = all 8 lanes are data; n = lanes 0..n-1 data, /T/ in lane n,
//             /I/ above it
//   err_inj : force lane 0 to /E/ (control) regardless of mod
//   rxd/rxc : resulting XGMII column
module xgmii_term_encode
  import xgmii_tx_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  mod,
  input  logic        err_inj,
  output logic [63:0] rxd,
  output logic [7:0]  rxc
);

  always_comb begin
    rxd = data;
    rxc = '0;
    if (mod != 3'd0) begin
      for (int k = 0; k < 8; k++) begin
        if (k == int'(mod)) begin
          rxd[8*k +: 8] = XGMII_TERM;
          rxc[k]        = 1'b1;
        end else if (k > int'(mod)) begin
          rxd[8*k +: 8] = XGMII_IDLE;
          rxc[k]        = 1'b1;
        end
      end
    end
    if (err_inj) begin
      rxd[7:0] = XGMII_ERROR;
      rxc[0]   = 1'b1;
    end
  end

endmodule

// File: rtl/xgmii_frame_tx.sv
// PHY-side XGMII frame transmitter: frames packet words into XGMII columns
// (start/preamble/SFD, data, terminate, idle gap) toward the MAC RX lanes.
//   clk_xgmii_rx / reset_xgmii_rx_n : clock, async active-low reset
//   pkt          : push interface (slave side), pkt_rdy registered
//   xgmii_rxd/c  : XGMII column, two register stages after acceptance
//   busy         : state is not IDLE
//   frame_cnt    : normally terminated frames (wraps)
//   underrun_cnt : aborted frames (saturates)
module xgmii_frame_tx
  import xgmii_tx_pkg::*;
#(
  parameter int IFG_WORDS = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk_xgmii_rx,
  input  logic             reset_xgmii_rx_n,
  xgmii_frame_tx_if.slave  pkt,
  output logic [63:0]      xgmii_rxd,
  output logic [7:0]       xgmii_rxc,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [15:0]      underrun_cnt
);

  // IFG counts down to zero, so load with IFG_WORDS-1.
  localparam logic [3:0] IFG_LAST = 4'(IFG_WORDS - 1);

  state_e             state_q, state_d;
  logic [3:0]         ifg_cnt_q, ifg_cnt_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic [63:0]        col_q, col_d;
  logic [7:0]         ctl_q, ctl_d;
  logic [63:0]        rxd_q;
  logic [7:0]         rxc_q;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]        underrun_cnt_q, underrun_cnt_d;

  logic        accept;
  logic [63:0] enc_rxd;
  logic [7:0]  enc_rxc;

  assign accept = pkt.pkt_val & rdy_q;

  // Non-eop words are full columns, which is exactly the mod=0 encoding.
  xgmii_term_encode u_enc (
    .data    (pkt.pkt_data),
    .mod     (pkt.pkt_eop ? pkt.pkt_mod : 3'd0),
    .err_inj (pkt.pkt_err_inj),
    .rxd     (enc_rxd),
    .rxc     (enc_rxc)
  );

  always_comb begin
    state_d        = state_q;
    ifg_cnt_d      = ifg_cnt_q;
    col_d          = IDLE_COLUMN;
    ctl_d          = CTRL_ALL;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    case (state_q)
      IDLE: begin
        // The sop word stays on the bus; it is taken in DATA next cycle.
        if (pkt.pkt_val && pkt.pkt_sop) begin
          col_d   = START_COLUMN;
          ctl_d   = CTRL_START;
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          col_d = enc_rxd;
          ctl_d = enc_rxc;
          if (pkt.pkt_eop) begin
            if (pkt.pkt_mod == 3'd0) begin
              state_d = TERM;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
              ifg_cnt_d   = IFG_LAST;
              state_d     = IFG;
            end
          end
        end else begin
          col_d = ABORT_COLUMN;
          if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
          state_d = DRAIN;
        end
      end
      TERM: begin
        col_d       = TERM_COLUMN;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        ifg_cnt_d   = IFG_LAST;
        state_d     = IFG;
      end
      DRAIN: begin
        if (accept && pkt.pkt_eop) begin
          ifg_cnt_d = IFG_LAST;
          state_d   = IFG;
        end
      end
      IFG: begin
        if (ifg_cnt_q == 4'd0) state_d = IDLE;
        else                   ifg_cnt_d = ifg_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == DATA) || (state_d == DRAIN);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
    if (!reset_xgmii_rx_n) begin
      state_q        <= IDLE;
      ifg_cnt_q      <= '0;
      rdy_q          <= 1'b0;
      busy_q         <= 1'b0;
      col_q          <= IDLE_COLUMN;
      ctl_q          <= CTRL_ALL;
      rxd_q          <= IDLE_COLUMN;
      rxc_q          <= CTRL_ALL;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      ifg_cnt_q      <= ifg_cnt_d;
      rdy_q          <= rdy_d;
      busy_q         <= busy_d;
      col_q          <= col_d;
      ctl_q          <= ctl_d;
      // Output stage: a word accepted at edge N is visible after edge N+1.
      rxd_q          <= col_q;
      rxc_q          <= ctl_q;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign pkt.pkt_rdy  = rdy_q;
  assign xgmii_rxd    = rxd_q;
  assign xgmii_rxc    = rxc_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_xgmii_frame_tx.sv
// Directed bench for xgmii_frame_tx: columns are logged every falling edge
// as {rxc, rxd} and compared against hand-computed sequences.
module tb_xgmii_frame_tx;

  localparam logic [71:0] C_IDLE  = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] C_START = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] C_TERM  = {8'hFF, 64'h07070707070707FD};

  logic        gclk;
  logic        grst_n;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic        busy;
  logic [31:0] frame_cnt;
  logic [15:0] underrun_cnt;

  int n_chk;
  int n_err;
  logic [71:0] cols[$];

  xgmii_frame_tx_if pif ();

  xgmii_frame_tx #(.IFG_WORDS(2), .CNT_W(32)) dut (
    .clk_xgmii_rx     (gclk),
    .reset_xgmii_rx_n (grst_n),
    .pkt              (pif),
    .xgmii_rxd        (rxd),
    .xgmii_rxc        (rxc),
    .busy             (busy),
    .frame_cnt        (frame_cnt),
    .underrun_cnt     (underrun_cnt)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  always @(negedge gclk) cols.push_back({rxc, rxd});

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until it is accepted (bounded).
  task automatic push(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] mod, input logic err);
    logic acc;
    acc = 1'b0;
    pif.pkt_val = 1'b1; pif.pkt_sop = sop; pif.pkt_eop = eop;
    pif.pkt_mod = mod;  pif.pkt_data = d;  pif.pkt_err_inj = err;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge gclk);
      acc = pif.pkt_rdy;
      @(posedge gclk);
    end
    if (!acc) chk("push_timeout", {71'd0, acc}, 72'd1);
    #1;
  endtask

  task automatic idle_bus(input int n);
    pif.pkt_val = 1'b0; pif.pkt_sop = 1'b0; pif.pkt_eop = 1'b0; pif.pkt_err_inj = 1'b0;
    repeat (n) @(posedge gclk);
    #1;
  endtask

  function automatic int find_col(input logic [71:0] c, input int from);
    for (int i = from; i < cols.size(); i++) if (cols[i] === c) return i;
    return -1;
  endfunction

  function automatic int find_busy_col();
    for (int i = 0; i < cols.size(); i++) if (cols[i] !== C_IDLE) return i;
    return -1;
  endfunction

  int b;
  int t;

  initial begin
    n_chk = 0; n_err = 0;
    pif.pkt_val = 0; pif.pkt_sop = 0; pif.pkt_eop = 0; pif.pkt_mod = 0;
    pif.pkt_data = 0; pif.pkt_err_inj = 0;
    grst_n = 1'b0;
    repeat (3) @(negedge gclk);
    chk("rst_col",   {rxc, rxd}, C_IDLE);
    chk("rst_rdy",   {71'd0, pif.pkt_rdy}, 72'd0);
    chk("rst_busy",  {71'd0, busy}, 72'd0);
    chk("rst_fcnt",  {40'd0, frame_cnt}, 72'd0);
    chk("rst_ucnt",  {56'd0, underrun_cnt}, 72'd0);
    grst_n = 1'b1;
    idle_bus(2);

    // 1: three full words, mod=0 -> separate terminate column
    cols.delete();
    push(64'h1111111111111111, 1, 0, 0, 0);
    push(64'h2222222222222222, 0, 0, 0, 0);
    push(64'h3333333333333333, 0, 1, 0, 0);
    idle_bus(8);
    b = find_busy_col();
    chk("t1_found", {71'd0, b >= 0}, 72'd1);
    if (b < 0) b = 0;
    chk("t1_start", cols[b],   C_START);
    chk("t1_d0",    cols[b+1], {8'h00, 64'h1111111111111111});
    chk("t1_d1",    cols[b+2], {8'h00, 64'h2222222222222222});
    chk("t1_d2",    cols[b+3], {8'h00, 64'h3333333333333333});
    chk("t1_term",  cols[b+4], C_TERM);
    chk("t1_ifg0",  cols[b+5], C_IDLE);
    chk("t1_ifg1",  cols[b+6], C_IDLE);
    chk("t1_fcnt",  {40'd0, frame_cnt}, 72'd1);
    chk("t1_busy",  {71'd0, busy}, 72'd0);

    // 2: eop mod=3 carries /T/ in-column, no separate TERM column
    cols.delete();
    push(64'h0000000000000000, 1, 0, 0, 0);
    push(64'hAABBCCDDEEFF0011, 0, 1, 3, 0);
    idle_bus(8);
    b = find_busy_col();
    if (b < 0) b = 0;
    chk("t2_start", cols[b],   C_START);
    chk("t2_d0",    cols[b+1], {8'h00, 64'h0});
    chk("t2_last",  cols[b+2], {8'hF8, 64'h07070707FDFF0011});
    chk("t2_noterm",cols[b+3], C_IDLE);
    chk("t2_fcnt",  {40'd0, frame_cnt}, 72'd2);

    // 3: back-to-back single-word frames with valid held high
    cols.delete();
    push(64'h4444444444444444, 1, 1, 0, 0);
    push(64'h5555555555555555, 1, 1, 0, 0);
    idle_bus(8);
    t = find_col(C_TERM, 0);
    chk("t3_found", {71'd0, t >= 0}, 72'd1);
    if (t < 0) t = 0;
    chk("t3_gap0",  cols[t+1], C_IDLE);
    chk("t3_gap1",  cols[t+2], C_IDLE);
    chk("t3_start", cols[t+3], C_START);
    chk("t3_d",     cols[t+4], {8'h00, 64'h5555555555555555});
    chk("t3_fcnt",  {40'd0, frame_cnt}, 72'd4);

    // 4: one-cycle underrun mid-frame, rest of frame drained
    cols.delete();
    push(64'h6666666666666666, 1, 0, 0, 0);
    push(64'h7777777777777777, 0, 0, 0, 0);
    idle_bus(1);
    push(64'h8888888888888888, 0, 0, 0, 0);
    push(64'h9999999999999999, 0, 1, 0, 0);
    idle_bus(8);
    b = find_busy_col();
    if (b < 0) b = 0;
    chk("t4_d1",    cols[b+2], {8'h00, 64'h7777777777777777});
    chk("t4_abort", cols[b+3], {8'hFF, 64'h070707070707FDFE});
    for (int i = 4; i < 9; i++) chk("t4_drain", cols[b+i], C_IDLE);
    chk("t4_ucnt",  {56'd0, underrun_cnt}, 72'd1);
    chk("t4_fcnt",  {40'd0, frame_cnt}, 72'd4);

    // 5: error injection on the second word
    cols.delete();
    push(64'hAAAAAAAAAAAAAAAA, 1, 0, 0, 0);
    push(64'h0123456789ABCDEF, 0, 0, 0, 1);
    push(64'hBBBBBBBBBBBBBBBB, 0, 1, 7, 0);
    idle_bus(8);
    b = find_busy_col();
    if (b < 0) b = 0;
    chk("t5_d0",    cols[b+1], {8'h00, 64'hAAAAAAAAAAAAAAAA});
    chk("t5_err",   cols[b+2], {8'h01, 64'h0123456789ABCDFE});
    chk("t5_mod7",  cols[b+3], {8'h80, 64'hFDBBBBBBBBBBBBBB});
    chk("t5_fcnt",  {40'd0, frame_cnt}, 72'd5);

    // 6: reset in DATA, then a clean frame
    push(64'hCCCCCCCCCCCCCCCC, 1, 0, 0, 0);
    push(64'hDDDDDDDDDDDDDDDD, 0, 0, 0, 0);
    pif.pkt_val = 1'b1; pif.pkt_data = 64'hEEEEEEEEEEEEEEEE;
    grst_n = 1'b0;
    #1;
    chk("t6_col",   {rxc, rxd}, C_IDLE);
    chk("t6_rdy",   {71'd0, pif.pkt_rdy}, 72'd0);
    chk("t6_busy",  {71'd0, busy}, 72'd0);
    pif.pkt_val = 1'b0;
    @(negedge gclk);
    grst_n = 1'b1;
    idle_bus(2);
    chk("t6_fcnt0", {40'd0, frame_cnt}, 72'd0);
    chk("t6_ucnt0", {56'd0, underrun_cnt}, 72'd0);
    cols.delete();
    push(64'h8877665544332211, 1, 1, 5, 0);
    idle_bus(8);
    b = find_busy_col();
    if (b < 0) b = 0;
    chk("t6_start", cols[b],   C_START);
    chk("t6_last",  cols[b+1], {8'hE0, 64'h0707FD5544332211});
    chk("t6_fcnt",  {40'd0, frame_cnt}, 72'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
